noc_rr_port_arbiter: RTL

//  Clocked round-robin arbiter and merge for one router output port.

---
 rtl/noc_rr_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/noc_rr_port_arbiter.sv
// rtl/noc_rr_port_arbiter.sv - round-robin burst arbiter merging NUM_IN requesters into one buffered output port
module noc_rr_port_arbiter #(
    parameter int WIDTH_packet = 14,
    parameter int NUM_IN       = 4,
    parameter int MAX_BURST    = 4,
    parameter int ID_W         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
    output logic [NUM_IN-1:0]              in_ready,
    output logic                           out_valid,
    output logic [WIDTH_packet-1:0]        out_data,
    input  logic                           out_ready,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_next;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         owner;
    logic [ID_W-1:0]         owner_next_ptr;
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_found;
    int                      pick_scan;
    logic [BW-1:0]           burst_cnt;
    logic                    owner_valid;
    logic                    can_accept;
    logic                    xfer;
    logic                    burst_done;
    logic                    release_grant;
    logic [WIDTH_packet-1:0] owner_data;

    assign owner_valid    = in_valid[owner];
    assign owner_data     = in_data[int'(owner)*WIDTH_packet +: WIDTH_packet];
    assign can_accept     = !out_valid || out_ready;
    assign xfer           = (state == GRANT) && owner_valid && can_accept;
    assign burst_done     = xfer && (burst_cnt == BW'(MAX_BURST - 1));
    assign release_grant  = (state == GRANT) && (burst_done || !owner_valid);
    assign owner_next_ptr = (int'(owner) == NUM_IN - 1) ? '0 : owner + 1'b1;
    assign busy           = (state == GRANT);

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_scan  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            pick_scan = (int'(rr_ptr) + k) % NUM_IN;
            if (!pick_found && in_valid[pick_scan]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(pick_scan);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state == GRANT) begin
            in_ready[owner] = can_accept;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = GRANT;
            GRANT:   if (release_grant) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                owner     <= pick_idx;
                grant_id  <= pick_idx;
                burst_cnt <= '0;
            end
            if (release_grant) begin
                rr_ptr <= owner_next_ptr;
            end
            // A same-cycle drain and accept refills the buffer without a bubble.
            if (xfer) begin
                out_data  <= owner_data;
                out_valid <= 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
